// File: rtl/vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// vga_frame_monitor
//
// VGA timing and content monitor on the pixel-clock domain. It locks to the
// vertical sync, measures line period, HS width, lines per frame and VS width
// against the parameters, and produces a per-frame pixel signature. After
// FRAMES complete frames it raises done and freezes every result until reset.
//
// Optional build macro: MON_CRC_EN
//   defined   : frame_sum is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB
//               first) over the 12-bit {r,g,b} sample of every cycle,
//               re-initialised at each VS leading edge.
//   undefined : frame_sum is the 16-bit wrap-around sum of {4'b0,r,g,b}.
//
// Ports:
//   pclk      in   pixel clock, sole clock
//   rst       in   asynchronous active-high reset
//   hs, vs    in   sync inputs from the observed design (active level SYNC_POL)
//   r, g, b   in   4-bit colour components
//   done      out  FRAMES frames measured (sticky)
//   frame_cnt out  completed frames, saturating at 16'hFFFF
//   frame_sum out  signature of the last completed frame
//   sum_valid out  one-cycle pulse when frame_sum/frame_cnt update
//   h_err     out  sticky: HS period != H_TOTAL
//   hsw_err   out  sticky: HS width != H_SYNC_LEN
//   v_err     out  sticky: lines per frame != V_TOTAL
//   vsw_err   out  sticky: VS width (in HS leading edges) != V_SYNC_LEN
//   err_line  out  line index of the first h_err/hsw_err
//
// sum_valid is a pure valid qualifier without a ready: frame_sum and
// frame_cnt are meaningful in the cycle sum_valid is high and are held
// afterwards; the monitor can never be stalled by its consumer.
// -----------------------------------------------------------------------------
module vga_frame_monitor #(
    parameter int H_TOTAL    = 1056,
    parameter int V_TOTAL    = 628,
    parameter int H_SYNC_LEN = 128,
    parameter int V_SYNC_LEN = 4,
    parameter int SYNC_POL   = 1,
    parameter int FRAMES     = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        done,
    output logic [15:0] frame_cnt,
    output logic [15:0] frame_sum,
    output logic        sum_valid,
    output logic        h_err,
    output logic        hsw_err,
    output logic        v_err,
    output logic        vsw_err,
    output logic [15:0] err_line
);

    typedef enum logic [1:0] {
        S_WAIT_INACTIVE = 2'd0,
        S_WAIT_EDGE     = 2'd1,
        S_MEASURE       = 2'd2,
        S_DONE          = 2'd3
    } state_t;

    localparam logic        ACT         = (SYNC_POL != 0);
    localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
    localparam logic [15:0] HS_LAST     = 16'(H_SYNC_LEN - 1);
    localparam logic [15:0] V_EXP       = 16'(V_TOTAL);
    localparam logic [15:0] VS_EXP      = 16'(V_SYNC_LEN);
    localparam logic [15:0] FRAMES_LAST = 16'(FRAMES - 1);

`ifdef MON_CRC_EN
    localparam logic [15:0] ACC_INIT = 16'hFFFF;

    // Twelve unrolled MSB-first CRC-16-CCITT bit steps.
    function automatic logic [15:0] crc12_step(input logic [15:0] crc_in,
                                               input logic [11:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`else
    localparam logic [15:0] ACC_INIT = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Input stage: one register for everything, a second for the syncs so
    // edges are detected on the registered copies.
    // ------------------------------------------------------------------
    logic        hs_q, hs_qq, vs_q, vs_qq;
    logic [11:0] pix_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            // Parked at the inactive level so reset release cannot fake an edge.
            hs_q  <= ~ACT;
            hs_qq <= ~ACT;
            vs_q  <= ~ACT;
            vs_qq <= ~ACT;
            pix_q <= 12'h000;
        end else begin
            hs_q  <= hs;
            hs_qq <= hs_q;
            vs_q  <= vs;
            vs_qq <= vs_q;
            pix_q <= {r, g, b};
        end
    end

    logic hs_lead, hs_trail, vs_lead, vs_trail, vs_act;

    assign hs_lead  = (hs_q == ACT) && (hs_qq != ACT);
    assign hs_trail = (hs_q != ACT) && (hs_qq == ACT);
    assign vs_lead  = (vs_q == ACT) && (vs_qq != ACT);
    assign vs_trail = (vs_q != ACT) && (vs_qq == ACT);
    assign vs_act   = (vs_q == ACT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state, state_nxt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            state <= S_WAIT_INACTIVE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_INACTIVE: if (!vs_act) state_nxt = S_WAIT_EDGE;
            S_WAIT_EDGE:     if (vs_lead) state_nxt = S_MEASURE;
            S_MEASURE:       if (vs_lead && frame_cnt == FRAMES_LAST) state_nxt = S_DONE;
            S_DONE:          state_nxt = S_DONE;
            default:         state_nxt = S_WAIT_INACTIVE;
        endcase
    end

    always_comb begin
        done = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Measurement datapath
    // ------------------------------------------------------------------
    logic [15:0] h_cnt;
    logic        h_valid;
    logic [15:0] line_cnt;
    logic [15:0] vs_lines;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic        set_h, set_hw;

`ifdef MON_CRC_EN
    assign acc_next = crc12_step(acc, pix_q);
`else
    assign acc_next = acc + {4'b0000, pix_q};
`endif

    // h_valid masks the first HS edge after lock, whose period is unknown,
    // and any trailing edge seen before a leading edge was measured.
    assign set_h  = hs_lead  && h_valid && (h_cnt != H_LAST);
    assign set_hw = hs_trail && h_valid && (h_cnt != HS_LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            h_cnt     <= 16'd0;
            h_valid   <= 1'b0;
            line_cnt  <= 16'd0;
            vs_lines  <= 16'd0;
            acc       <= 16'd0;
            frame_cnt <= 16'd0;
            frame_sum <= 16'd0;
            sum_valid <= 1'b0;
            h_err     <= 1'b0;
            hsw_err   <= 1'b0;
            v_err     <= 1'b0;
            vsw_err   <= 1'b0;
            err_line  <= 16'd0;
        end else begin
            sum_valid <= 1'b0;
            case (state)
                S_WAIT_EDGE: begin
                    if (vs_lead) begin
                        // A coincident HS edge opens line 1 of the first frame,
                        // matching how later frames count it.
                        h_cnt    <= 16'd0;
                        h_valid  <= hs_lead;
                        line_cnt <= hs_lead ? 16'd1 : 16'd0;
                        vs_lines <= hs_lead ? 16'd1 : 16'd0;
                        acc      <= ACC_INIT;
                    end
                end
                S_MEASURE: begin
                    h_cnt <= h_cnt + 16'd1;
                    acc   <= acc_next;

                    if (hs_lead) begin
                        h_cnt   <= 16'd0;
                        h_valid <= 1'b1;
                    end
                    if (set_h)
                        h_err <= 1'b1;
                    if (set_hw)
                        hsw_err <= 1'b1;
                    // Reports the line being measured when the fault shows up.
                    if ((set_h || set_hw) && !h_err && !hsw_err)
                        err_line <= line_cnt;

                    if (vs_lead)
                        vs_lines <= hs_lead ? 16'd1 : 16'd0;
                    else if (vs_act && hs_lead)
                        vs_lines <= vs_lines + 16'd1;
                    if (vs_trail && vs_lines != VS_EXP)
                        vsw_err <= 1'b1;

                    // VS closes the frame first; a coincident HS edge then
                    // becomes line 1 of the new frame.
                    if (vs_lead) begin
                        if (line_cnt != V_EXP)
                            v_err <= 1'b1;
                        line_cnt  <= hs_lead ? 16'd1 : 16'd0;
                        if (frame_cnt != 16'hFFFF)
                            frame_cnt <= frame_cnt + 16'd1;
                        frame_sum <= acc_next;
                        sum_valid <= 1'b1;
                        acc       <= ACC_INIT;
                    end else if (hs_lead) begin
                        line_cnt <= line_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// Bench for vga_frame_monitor with a reduced raster (40x12, HS 6, VS 3) so each
// frame is 480 samples. Expected {frame_cnt, frame_sum} pairs are pushed per
// test; a monitor pops them on every sum_valid. Sums are for the additive
// signature: frame_sum = samples * pixel mod 2^16.
// -----------------------------------------------------------------------------
module tb_vga_frame_monitor;

    localparam int H   = 40;
    localparam int V   = 12;
    localparam int HSW = 6;
    localparam int VSW = 3;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        hs   = 1'b0;
    logic        vs   = 1'b0;
    logic [3:0]  r    = 4'h0;
    logic [3:0]  g    = 4'h0;
    logic [3:0]  b    = 4'h0;
    logic        done;
    logic [15:0] frame_cnt;
    logic [15:0] frame_sum;
    logic        sum_valid;
    logic        h_err;
    logic        hsw_err;
    logic        v_err;
    logic        vsw_err;
    logic [15:0] err_line;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    vga_frame_monitor #(
        .H_TOTAL    (H),
        .V_TOTAL    (V),
        .H_SYNC_LEN (HSW),
        .V_SYNC_LEN (VSW),
        .SYNC_POL   (1),
        .FRAMES     (2)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .hs        (hs),
        .vs        (vs),
        .r         (r),
        .g         (g),
        .b         (b),
        .done      (done),
        .frame_cnt (frame_cnt),
        .frame_sum (frame_sum),
        .sum_valid (sum_valid),
        .h_err     (h_err),
        .hsw_err   (hsw_err),
        .v_err     (v_err),
        .vsw_err   (vsw_err),
        .err_line  (err_line)
    );

    // Clock
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 ns after the rising edge.
    task automatic drive(input logic hs_v, input logic vs_v, input logic [11:0] pix);
        @(posedge pclk);
        #1;
        hs = hs_v;
        vs = vs_v;
        {r, g, b} = pix;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'h000);
    endtask

    task automatic pulse_reset();
        @(posedge pclk);
        #1;
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
    endtask

    // Lines numbered 1..V; line 1 starts at the VS leading edge with a
    // coincident HS leading edge. One line may be one cycle short, one line
    // may have an HS pulse one cycle too wide.
    task automatic gen_frames(input int nframes, input logic [11:0] pix, input int vs_len,
                              input int short_f, input int short_l,
                              input int wide_f, input int wide_l);
        for (int f = 0; f < nframes; f++) begin
            for (int l = 1; l <= V; l++) begin
                int len;
                int hw;
                len = (f == short_f && l == short_l) ? H - 1 : H;
                hw  = (f == wide_f && l == wide_l) ? HSW + 1 : HSW;
                for (int c = 0; c < len; c++)
                    drive(c < hw, l <= vs_len, pix);
            end
        end
        idle(8);
    endtask

    task automatic check_end(input string tn, input logic e_done, input logic [15:0] e_cnt,
                             input logic e_h, input logic e_hw, input logic e_v,
                             input logic e_vw, input logic [15:0] e_line);
        @(negedge pclk);
        check({tn, "_done"},     {31'd0, done},    {31'd0, e_done});
        check({tn, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, e_cnt});
        check({tn, "_h_err"},    {31'd0, h_err},   {31'd0, e_h});
        check({tn, "_hsw_err"},  {31'd0, hsw_err}, {31'd0, e_hw});
        check({tn, "_v_err"},    {31'd0, v_err},   {31'd0, e_v});
        check({tn, "_vsw_err"},  {31'd0, vsw_err}, {31'd0, e_vw});
        check({tn, "_err_line"}, {16'd0, err_line}, {16'd0, e_line});
        check({tn, "_pending"},  exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor
    always @(negedge pclk) begin
        if (!rst && sum_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sum_valid_unexpected: got cnt=%0d sum=%h, required no pulse",
                         frame_cnt, frame_sum);
            end else begin
                logic [31:0] exp;
                exp = exp_q.pop_front();
                if ({frame_cnt, frame_sum} !== exp) begin
                    errors++;
                    $display("FAIL frame_result: got cnt=%0d sum=%h, required cnt=%0d sum=%h",
                             frame_cnt, frame_sum, exp[31:16], exp[15:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_frame_sum", {16'd0, frame_sum}, 32'd0);
        check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        check("rst_flags",     {28'd0, h_err, hsw_err, v_err, vsw_err}, 32'd0);
        check("rst_err_line",  {16'd0, err_line},  32'd0);
        @(posedge pclk);
        #1;
        rst = 1'b0;

        // 1: nominal, pixel 0x001 -> 480
        idle(4);
        exp_q.push_back({16'd1, 16'h01E0});
        exp_q.push_back({16'd2, 16'h01E0});
        gen_frames(3, 12'h001, VSW, -1, 0, -1, 0);
        check_end("t1", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // 2: line 5 of frame 0 one cycle short, pixel 0x002 -> 479*2, 480*2
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'h03BE});
        exp_q.push_back({16'd2, 16'h03C0});
        gen_frames(3, 12'h002, VSW, 0, 5, -1, 0);
        check_end("t2", 1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);

        // 3: VS active 5 lines, pixel 0x010 -> 480*16
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'h1E00});
        exp_q.push_back({16'd2, 16'h1E00});
        gen_frames(3, 12'h010, 5, -1, 0, -1, 0);
        check_end("t3", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);

        // 4: constant 0xFFF -> 480*4095 mod 2^16 = 0xFE20
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'hFE20});
        exp_q.push_back({16'd2, 16'hFE20});
        gen_frames(3, 12'hFFF, VSW, -1, 0, -1, 0);
        check_end("t4", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // 5: reset in the middle of frame 1, relock on frame 2; pixel 0x100
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'hE000});
        exp_q.push_back({16'd1, 16'hE000});
        exp_q.push_back({16'd2, 16'hE000});
        fork
            gen_frames(5, 12'h100, VSW, -1, 0, -1, 0);
            begin
                repeat (4 + H * V + H * V / 2) @(posedge pclk);
                @(negedge pclk);
                check("t5_pre_rst_cnt", {16'd0, frame_cnt}, 32'd1);
                @(posedge pclk);
                #1;
                rst = 1'b1;
                @(negedge pclk);
                check("t5_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
                check("t5_rst_frame_sum", {16'd0, frame_sum}, 32'd0);
                check("t5_rst_done",      {31'd0, done},      32'd0);
                @(posedge pclk);
                #1;
                rst = 1'b0;
            end
        join
        check_end("t5", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // 6: coincident HS/VS edges; line 1 of frame 1 short -> err_line 1
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'h05A0});
        exp_q.push_back({16'd2, 16'h059D});
        gen_frames(3, 12'h003, VSW, 1, 1, -1, 0);
        check_end("t6", 1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

        // 7: HS one cycle too wide on line 3 of frame 0, pixel 0
        pulse_reset();
        idle(4);
        exp_q.push_back({16'd1, 16'h0000});
        exp_q.push_back({16'd2, 16'h0000});
        gen_frames(3, 12'h000, VSW, -1, 0, 0, 3);
        check_end("t7", 1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
